prescaled_digit_counter: RTL and testbench
==========================================

Name: prescaled_digit_counter

Overview:
Single-clock, multi-digit modulo counter with a built-in prescaler. It generalises our divide-then-count blocks into one parameterised module. There is no derived clock: the prescaler produces an internal one-cycle step enable. Provides up/down counting, synchronous preload and wrap (carry/borrow) indication. Used for display timers and event counters feeding the 7-segment/BCD path.

Parameters:
DIV, 500, prescale ratio; one count step per DIV enabled clocks; legal 1..1024
DIGITS, 4, number of cascaded digits; legal 1..8
MOD, 10, modulus of every digit; legal 2..16

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-low
en  in  1  count enable; gates the prescaler
up  in  1  direction; 1 = up, 0 = down; sampled on step edges only
load  in  1  synchronous preload strobe
load_val  in  DIGITS*4  preload value, digit 0 in bits [3:0]
count  out  DIGITS*4  current value, digit i in bits [4i+3:4i]
tick  out  1  registered one-cycle pulse, high the cycle after every count step
carry  out  1  registered one-cycle pulse, high the cycle after a full-counter wrap

Behaviour:
- Fixed interface: one clock (clk); reset rst is synchronous and active-low.
- Priority at each posedge clk: reset > load > step > hold.
- Reset (rst==0 at edge): pre_cnt=0, count=0, tick=0, carry=0. Load and en are ignored.
- Prescaler: pre_cnt width max(1,$clog2(DIV)).
  - When en=1, pre_cnt increments.
  - At DIV-1 it returns to 0.
  - step = en & (pre_cnt==DIV-1). DIV=1 gives step on every enabled cycle.
  - en=0 holds pre_cnt; it is not cleared.
- Load: count<=load_val, pre_cnt<=0, tick<=0, carry<=0. Any digit >= MOD is clamped to MOD-1. A load wins over a coincident step.
- Step, up=1:
  - Digit 0 increments.
  - Digit i>0 increments only when all lower digits are MOD-1.
  - A digit at MOD-1 that increments wraps to 0.
- Step, up=0: mirror of up. Digit 0 decrements. Digit i>0 decrements only when all lower digits are 0. A digit at 0 wraps to MOD-1.
- Full wrap: up from all MOD-1 to all 0, or down from all 0 to all MOD-1. carry=1 in the following cycle, together with tick.
- tick, carry: default 0 each cycle; never high for more than one consecutive cycle when DIV>1.
- Latency: count updates on the step edge; tick/carry are visible one cycle later, aligned with the new count.
- Direction change between steps: takes effect at the next step; pre_cnt is unaffected.

Optional Feature:
CNT_SATURATE_EN
- Defined: counter saturates instead of wrapping. Up at all MOD-1 holds; down at all 0 holds. On such a blocked step, tick=1 and carry=1 (limit indication) while count is unchanged.
- Undefined: wrap behaviour as above.

Decomposition:
- Package cnt_pkg holds:
  - DIGIT_W=4 constant
  - typedef digit_t (logic [3:0])
  - function digit_next(digit_t d, logic up, int mod), returns next value plus wrap flag
- Sub-module tick_gen: the prescaler. Parameter DIV; ports clk, rst, en, step. Instantiated once.
- Digit chain: generate loop in the top module.

Test Plan:
All tests use DIV=4, DIGITS=2, MOD=10 unless noted.
1. Hold rst=0 for 3 cycles with en=1 -> count=8'h00, tick=0, carry=0. Release with up=1 -> count=8'h01 four clocks later; tick high one cycle after.
2. Load 8'h98, up=1, run 2 steps -> count 8'h99 then 8'h00. carry=1 only in the cycle after the 8'h00 step, coincident with tick.
3. Load 8'h00, up=0, one step -> count=8'h99, carry=1. Next step -> 8'h98, carry=0.
4. Drop en at pre_cnt=2 for 10 cycles -> count frozen, no tick. Re-enable -> step after 2 enabled cycles.
5. Assert load with load_val=8'hFA on a step edge -> count=8'h99 (clamped), tick=0. Assert rst=0 at count 8'h57 -> next cycle count=8'h00.
6. With CNT_SATURATE_EN defined: load 8'h99, up=1, one step -> count stays 8'h99, tick=1, carry=1. Without the macro -> 8'h00.

Source files
------------

// File: rtl/prescaled_digit_counter_pkg.sv
// Shared digit types and the per-digit next-value helper for the prescaled digit counter.
package cnt_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t val;
        logic   wrap;
    } digit_res_t;

    // wrap is set when the digit leaves its terminal value (MOD-1 going up, 0 going down).
    function automatic digit_res_t digit_next(digit_t d, logic up, int mod);
        digit_res_t r;
        if (up) begin
            if (int'(d) >= mod - 1) begin
                r.val  = '0;
                r.wrap = 1'b1;
            end else begin
                r.val  = d + 4'd1;
                r.wrap = 1'b0;
            end
        end else begin
            if (d == '0) begin
                r.val  = DIGIT_W'(mod - 1);
                r.wrap = 1'b1;
            end else begin
                r.val  = d - 4'd1;
                r.wrap = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prescaled_digit_counter_tick_gen.sv
// Prescaler: free-running modulo-DIV counter producing a one-cycle step enable.
module tick_gen #(
    parameter int DIV = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_cnt;

    // en=0 freezes the phase instead of clearing it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    assign step = en && (pre_cnt == PRE_LAST);

endmodule

// File: rtl/prescaled_digit_counter.sv
// Multi-digit up/down modulo counter with built-in prescaler, preload and wrap pulse.
// Define CNT_SATURATE_EN to hold at the limits instead of wrapping.
module prescaled_digit_counter
    import cnt_pkg::*;
#(
    parameter int DIV    = 500,
    parameter int DIGITS = 4,
    parameter int MOD    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_val,
    output logic [DIGITS*DIGIT_W-1:0] count,
    output logic                      tick,
    output logic                      carry
);

    function automatic digit_t clamp_digit(digit_t d);
        return (int'(d) >= MOD) ? digit_t'(MOD - 1) : d;
    endfunction

    logic              step;
    logic              step_go;
    logic [DIGITS-1:0] term;
    logic [DIGITS:0]   at_lim;

    // A load restarts the prescaler phase, so it shares the synchronous clear.
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst && !load),
        .en   (en),
        .step (step)
    );

    // at_lim[i]: every digit below i sits at its terminal value for the current direction.
    always_comb begin
        at_lim    = '0;
        at_lim[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            at_lim[i+1] = at_lim[i] & term[i];
        end
    end

`ifdef CNT_SATURATE_EN
    assign step_go = step && !at_lim[DIGITS];
`else
    assign step_go = step;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        digit_t     dig_q;
        digit_res_t nxt;

        assign nxt     = digit_next(dig_q, up, MOD);
        assign term[i] = nxt.wrap;

        always_ff @(posedge clk) begin
            if (!rst) begin
                dig_q <= '0;
            end else if (load) begin
                dig_q <= clamp_digit(load_val[i*DIGIT_W +: DIGIT_W]);
            end else if (step_go && at_lim[i]) begin
                dig_q <= nxt.val;
            end
        end

        assign count[i*DIGIT_W +: DIGIT_W] = dig_q;
    end

    // Full-counter terminal on a step: a wrap, or a blocked step when saturating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end else if (load) begin
            tick  <= 1'b0;
            carry <= 1'b0;
        end else begin
            tick  <= step;
            carry <= step && at_lim[DIGITS];
        end
    end

endmodule

// File: tb/tb_prescaled_digit_counter.sv
// Directed testbench for prescaled_digit_counter (DIV=4, DIGITS=2, MOD=10).
module tb_prescaled_digit_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tick;
    logic       carry;

    int n_vec = 0;
    int n_bad = 0;

    prescaled_digit_counter #(
        .DIV    (4),
        .DIGITS (2),
        .MOD    (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    // Advance n active edges, then settle 1 time unit past the last edge.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        clk_n(1);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
        clk_n(3);
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL reset_count: got %h want 00", count); end
        n_vec++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_vec++; if (carry !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b want 0", carry); end
        rst = 1'b1;
        clk_n(3);
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL pre_step_count: got %h want 00", count); end
        n_vec++; if (tick !== 1'b0) begin n_bad++; $display("FAIL pre_step_tick: got %b want 0", tick); end
        clk_n(1);
        n_vec++; if (count !== 8'h01) begin n_bad++; $display("FAIL first_step_count: got %h want 01", count); end
        n_vec++; if (tick !== 1'b1) begin n_bad++; $display("FAIL first_step_tick: got %b want 1", tick); end
        clk_n(1);
        n_vec++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b want 0", tick); end
        n_vec++; if (count !== 8'h01) begin n_bad++; $display("FAIL hold_count: got %h want 01", count); end
    endtask

    task automatic test_wrap_up;
        up = 1'b1;
        do_load(8'h98);
        n_vec++; if (count !== 8'h98) begin n_bad++; $display("FAIL load98: got %h want 98", count); end
        clk_n(4);
        n_vec++; if (count !== 8'h99) begin n_bad++; $display("FAIL up_99: got %h want 99", count); end
        n_vec++; if (carry !== 1'b0) begin n_bad++; $display("FAIL up_99_carry: got %b want 0", carry); end
        for (int k = 0; k < 3; k++) begin
            clk_n(1);
            n_vec++; if (carry !== 1'b0) begin n_bad++; $display("FAIL carry_idle: got %b want 0", carry); end
        end
        clk_n(1);
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL up_wrap: got %h want 00", count); end
        n_vec++; if (carry !== 1'b1) begin n_bad++; $display("FAIL up_wrap_carry: got %b want 1", carry); end
        n_vec++; if (tick !== 1'b1) begin n_bad++; $display("FAIL up_wrap_tick: got %b want 1", tick); end
        clk_n(1);
        n_vec++; if (carry !== 1'b0) begin n_bad++; $display("FAIL carry_width: got %b want 0", carry); end
    endtask

    task automatic test_wrap_down;
        up = 1'b0;
        do_load(8'h00);
        clk_n(4);
        n_vec++; if (count !== 8'h99) begin n_bad++; $display("FAIL down_wrap: got %h want 99", count); end
        n_vec++; if (carry !== 1'b1) begin n_bad++; $display("FAIL down_wrap_carry: got %b want 1", carry); end
        clk_n(4);
        n_vec++; if (count !== 8'h98) begin n_bad++; $display("FAIL down_98: got %h want 98", count); end
        n_vec++; if (carry !== 1'b0) begin n_bad++; $display("FAIL down_98_carry: got %b want 0", carry); end
        n_vec++; if (tick !== 1'b1) begin n_bad++; $display("FAIL down_98_tick: got %b want 1", tick); end
    endtask

    task automatic test_dir_change;
        up = 1'b0;
        do_load(8'h10);
        clk_n(4);
        n_vec++; if (count !== 8'h09) begin n_bad++; $display("FAIL borrow: got %h want 09", count); end
        up = 1'b1;
        clk_n(4);
        n_vec++; if (count !== 8'h10) begin n_bad++; $display("FAIL carry_digit: got %h want 10", count); end
        clk_n(4);
        n_vec++; if (count !== 8'h11) begin n_bad++; $display("FAIL up_11: got %h want 11", count); end
    endtask

    task automatic test_en_gate;
        up = 1'b1;
        do_load(8'h00);
        clk_n(2);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            clk_n(1);
            n_vec++; if (count !== 8'h00 || tick !== 1'b0) begin
                n_bad++; $display("FAIL en_freeze: got %h/%b want 00/0", count, tick);
            end
        end
        en = 1'b1;
        clk_n(1);
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL reen_1: got %h want 00", count); end
        clk_n(1);
        n_vec++; if (count !== 8'h01) begin n_bad++; $display("FAIL reen_2: got %h want 01", count); end
        n_vec++; if (tick !== 1'b1) begin n_bad++; $display("FAIL reen_tick: got %b want 1", tick); end
    endtask

    task automatic test_load_clamp;
        up = 1'b1;
        do_load(8'h00);
        clk_n(3);
        do_load(8'hFA);
        n_vec++; if (count !== 8'h99) begin n_bad++; $display("FAIL clamp: got %h want 99", count); end
        n_vec++; if (tick !== 1'b0) begin n_bad++; $display("FAIL load_over_step_tick: got %b want 0", tick); end
        do_load(8'h57);
        n_vec++; if (count !== 8'h57) begin n_bad++; $display("FAIL load57: got %h want 57", count); end
        rst = 1'b0;
        clk_n(1);
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL mid_reset: got %h want 00", count); end
        rst = 1'b1;
    endtask

    task automatic test_limit;
        up = 1'b1;
        do_load(8'h99);
        clk_n(4);
`ifdef CNT_SATURATE_EN
        n_vec++; if (count !== 8'h99) begin n_bad++; $display("FAIL limit_count: got %h want 99", count); end
`else
        n_vec++; if (count !== 8'h00) begin n_bad++; $display("FAIL limit_count: got %h want 00", count); end
`endif
        n_vec++; if (tick !== 1'b1) begin n_bad++; $display("FAIL limit_tick: got %b want 1", tick); end
        n_vec++; if (carry !== 1'b1) begin n_bad++; $display("FAIL limit_carry: got %b want 1", carry); end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_dir_change();
        test_en_gate();
        test_load_clamp();
        test_limit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
